motor_pwm_ramp: RTL and testbench
=================================

// Module: motor_pwm_ramp
// PURPOSE
//  Next-generation multi-channel H-bridge PWM driver. Converts per-channel numeric duty and
//  direction commands into la/lb-style bridge pin pairs, clocked from the 100 kHz PLL output.
//  Adds slew-rate limiting, safe reversal with dead time, and period-aligned updates.
//  Sits between the control/line-follow logic and the motor driver pins.
// PARAMETERS
//  NCH          2    number of motor channels
//  DW           8    duty command width (bits)
//  PERIOD       100  clocks per PWM period (100 -> 1 kHz at 100 kHz); 2..2**DW-1
//  STEP         10   max change of applied duty per period; 0 = no ramp (jump to target)
//  DEAD_PERIODS 2    whole periods with both pins low during a direction reversal; >=1
// PORTS
//  khz100      in   1       100 kHz clock; all logic on posedge
//  rst_n       in   1       synchronous active-low reset
//  dir         in   NCH     per-channel direction: 1 forward, 0 backward
//  duty        in   NCH*DW  per-channel target duty; ch i = duty[i*DW +: DW]
//  pin_a       out  NCH     bridge pin A (driven when forward)
//  pin_b       out  NCH     bridge pin B (driven when backward)
//  busy        out  NCH     1 while channel is in RAMP_DOWN or DEAD
//  period_tick out  1       1 for one clock when cnt == PERIOD-1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): cnt=0, cur=0, dir_cur=1, state=RUN, pin_a=pin_b=0, busy=0,
//   period_tick=0. Reset mid-period or mid-reversal aborts immediately; no residual drive.
//  Counter: cnt counts 0..PERIOD-1 then wraps to 0; shared by all channels.
//  Boundary = clock where cnt==PERIOD-1. dir/duty are sampled only at a boundary; changes
//   between boundaries are ignored until the next one. tgt = min(duty_i, PERIOD) (saturate).
//  Per-channel FSM, evaluated at boundary only:
//   RUN:       dir_i==dir_cur -> cur moves toward tgt by min(STEP,|tgt-cur|) (STEP=0: cur=tgt).
//              dir_i!=dir_cur -> RAMP_DOWN; if cur==0 go straight to DEAD (dcnt=DEAD_PERIODS).
//   RAMP_DOWN: cur -= min(STEP,cur) (STEP=0: cur=0). If dir_i returns to dir_cur -> RUN
//              (ramping toward tgt resumes next boundary). When cur reaches 0 -> DEAD.
//   DEAD:      dcnt decrements per boundary; on reaching 0: dir_cur=dir_i, cur=0, -> RUN.
//              Direction flips during DEAD are not aborts; the final dir_i is adopted.
//  Applied cur and state take effect in the period starting at cnt==0 after the boundary.
//  Output (registered, 1-clock latency from cnt): level = (cnt < cur).
//   RUN/RAMP_DOWN: pin_a = dir_cur & level; pin_b = ~dir_cur & level. DEAD: both 0.
//   pin_a and pin_b are never 1 simultaneously (except brake, below).
//  cur==0 -> pins low all period; cur==PERIOD -> high all period (100%).
//  busy = (state != RUN), registered alongside pins.
// CONFIGURATION
//  MOTOR_BRAKE_EN defined: extra input brake [NCH] (after duty). brake_i=1 at any clock ->
//   next clock pin_a_i=pin_b_i=1 (short-brake), cur=0, state=RUN, dir_cur=dir_i, busy=0;
//   overrides FSM and boundary timing. On release, channel ramps up from 0 at next boundary.
//  MOTOR_BRAKE_EN undefined: no brake port; behaviour exactly as above.
// TESTING  (NCH=2, DW=8, PERIOD=100, STEP=10, DEAD_PERIODS=2)
//  1 Reset: rst_n=0 for 3 clks with duty=50 -> pins 0, busy 0; cnt restarts at 0 after release.
//  2 Ramp up: dir=1, duty=35 from reset -> ch high-time 10,20,30,35,35 clocks in successive
//    periods; pin_b stays 0; period_tick every 100 clocks.
//  3 Saturation: duty=255, STEP=0 build -> pin_a high all 100 clocks of each period.
//  4 Reversal: cur=30 fwd, set dir=0 -> high-time 20,10, then 2 periods both low (busy=1),
//    then pin_b high 10,20,30; pin_a and pin_b never both 1.
//  5 Abort reversal: during RAMP_DOWN (cur=20) restore dir=1 -> RUN, ramps back up to 30, no DEAD.
//  6 MOTOR_BRAKE_EN: brake=1 mid-period at cur=30 -> both pins 1 next clock; release ->
//    high-time restarts at 10.

Source files
------------

// File: rtl/motor_pwm_ramp.sv
// rtl/motor_pwm_ramp.sv - multi-channel H-bridge PWM driver with slew limiting and dead-time reversal; MOTOR_BRAKE_EN adds a short-brake input
module motor_pwm_ramp #(
  parameter int NCH          = 2,
  parameter int DW           = 8,
  parameter int PERIOD       = 100,
  parameter int STEP         = 10,
  parameter int DEAD_PERIODS = 2
) (
  input  logic              khz100,
  input  logic              rst_n,
  input  logic [NCH-1:0]    dir,
  input  logic [NCH*DW-1:0] duty,
`ifdef MOTOR_BRAKE_EN
  input  logic [NCH-1:0]    brake,
`endif
  output logic [NCH-1:0]    pin_a,
  output logic [NCH-1:0]    pin_b,
  output logic [NCH-1:0]    busy,
  output logic              period_tick
);

  localparam int DCW = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);
  localparam logic [DW-1:0]  LAST   = DW'(PERIOD - 1);
  localparam logic [DW-1:0]  PER_V  = DW'(PERIOD);
  localparam logic [DW-1:0]  STEP_V = DW'(STEP);
  localparam logic [DCW-1:0] DEAD_V = DCW'(DEAD_PERIODS);

  typedef enum logic [1:0] {RUN, RAMP_DOWN, DEAD} state_t;

  logic [DW-1:0] cnt;
  logic          boundary;

  assign boundary    = (cnt == LAST);
  assign period_tick = boundary;

  // Shared period counter, wraps at PERIOD-1
  always_ff @(posedge khz100) begin
    if (!rst_n)        cnt <= '0;
    else if (boundary) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t         state, state_nx;
    logic [DW-1:0]  cur, cur_nx, tgt, toward, down, duty_i;
    logic [DCW-1:0] dcnt, dcnt_nx;
    logic           dir_cur, dir_cur_nx;
    logic           brk, level;
    logic           pa_q, pb_q, bz_q;

`ifdef MOTOR_BRAKE_EN
    assign brk = brake[i];
`else
    assign brk = 1'b0;
`endif

    assign duty_i = duty[i*DW +: DW];
    assign tgt    = (duty_i > PER_V) ? PER_V : duty_i;
    assign level  = (cnt < cur);

    // Slew-limited candidates: one step toward target, one step toward zero
    always_comb begin
      toward = tgt;
      down   = '0;
      if (STEP != 0) begin
        if (tgt >= cur) toward = ((tgt - cur) <= STEP_V) ? tgt : cur + STEP_V;
        else            toward = ((cur - tgt) <= STEP_V) ? tgt : cur - STEP_V;
        down = (cur <= STEP_V) ? '0 : cur - STEP_V;
      end
    end

    // Next-state logic, only acts on the period boundary
    always_comb begin
      state_nx   = state;
      cur_nx     = cur;
      dcnt_nx    = dcnt;
      dir_cur_nx = dir_cur;
      if (boundary) begin
        case (state)
          RUN: begin
            if (dir[i] == dir_cur) begin
              cur_nx = toward;
            end else begin
              cur_nx = down;
              if (down == '0) begin
                state_nx = DEAD;
                dcnt_nx  = DEAD_V;
              end else begin
                state_nx = RAMP_DOWN;
              end
            end
          end
          RAMP_DOWN: begin
            if (dir[i] == dir_cur) begin
              state_nx = RUN;
            end else begin
              cur_nx = down;
              if (down == '0) begin
                state_nx = DEAD;
                dcnt_nx  = DEAD_V;
              end
            end
          end
          DEAD: begin
            dcnt_nx = dcnt - 1'b1;
            if (dcnt <= DCW'(1)) begin
              state_nx   = RUN;
              dir_cur_nx = dir[i];
              cur_nx     = '0;
              dcnt_nx    = '0;
            end
          end
          default: state_nx = RUN;
        endcase
      end
    end

    // Channel state register; brake overrides everything except reset
    always_ff @(posedge khz100) begin
      if (!rst_n) begin
        state   <= RUN;
        cur     <= '0;
        dcnt    <= '0;
        dir_cur <= 1'b1;
      end else if (brk) begin
        state   <= RUN;
        cur     <= '0;
        dcnt    <= '0;
        dir_cur <= dir[i];
      end else begin
        state   <= state_nx;
        cur     <= cur_nx;
        dcnt    <= dcnt_nx;
        dir_cur <= dir_cur_nx;
      end
    end

    // Registered bridge pins and busy flag, one clock behind cnt
    always_ff @(posedge khz100) begin
      if (!rst_n) begin
        pa_q <= 1'b0;
        pb_q <= 1'b0;
        bz_q <= 1'b0;
      end else if (brk) begin
        pa_q <= 1'b1;
        pb_q <= 1'b1;
        bz_q <= 1'b0;
      end else begin
        pa_q <= (state != DEAD) &  dir_cur & level;
        pb_q <= (state != DEAD) & ~dir_cur & level;
        bz_q <= (state != RUN);
      end
    end

    assign pin_a[i] = pa_q;
    assign pin_b[i] = pb_q;
    assign busy[i]  = bz_q;
  end

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// tb/tb_motor_pwm_ramp.sv - directed self-checking bench for motor_pwm_ramp
`timescale 1ns/1ps
module tb_motor_pwm_ramp;

  localparam int PERIOD = 100;

  logic        khz100 = 1'b0;
  logic        rst_n;
  logic [1:0]  dir;
  logic [15:0] duty;
  logic [1:0]  pin_a, pin_b, busy;
  logic        period_tick;
  logic [1:0]  sat_dir  = 2'b11;
  logic [15:0] sat_duty = 16'hFFFF;
  logic [1:0]  sat_a, sat_b, sat_busy;
  logic        sat_tick;
`ifdef MOTOR_BRAKE_EN
  logic [1:0]  brake = 2'b00;
  logic [1:0]  sat_brake = 2'b00;
`endif

  int cmp_count  = 0;
  int fail_count = 0;

  int ha0, ha1, hb0, hb1, bz0, bz1, sat_hi, sat_lo, ticks;
  logic overlap;

  always #5 khz100 = ~khz100;

  motor_pwm_ramp #(.NCH(2), .DW(8), .PERIOD(100), .STEP(10), .DEAD_PERIODS(2)) dut (
    .khz100(khz100), .rst_n(rst_n), .dir(dir), .duty(duty),
`ifdef MOTOR_BRAKE_EN
    .brake(brake),
`endif
    .pin_a(pin_a), .pin_b(pin_b), .busy(busy), .period_tick(period_tick)
  );

  motor_pwm_ramp #(.NCH(2), .DW(8), .PERIOD(100), .STEP(0), .DEAD_PERIODS(2)) u_sat (
    .khz100(khz100), .rst_n(rst_n), .dir(sat_dir), .duty(sat_duty),
`ifdef MOTOR_BRAKE_EN
    .brake(sat_brake),
`endif
    .pin_a(sat_a), .pin_b(sat_b), .busy(sat_busy), .period_tick(sat_tick)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sync_period;
    int n = 0;
    while (!period_tick && n < 300) begin
      @(negedge khz100);
      n++;
    end
    cmp_count++;
    if (period_tick !== 1'b1) begin
      $display("FAIL sync: period_tick not seen within 300 clocks");
      fail_count++;
    end
    @(negedge khz100);
  endtask

  task automatic measure(input bit glitch);
    ha0 = 0; ha1 = 0; hb0 = 0; hb1 = 0; bz0 = 0; bz1 = 0;
    sat_hi = 0; sat_lo = 0; ticks = 0; overlap = 1'b0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge khz100);
      if (pin_a[0]) ha0++;
      if (pin_a[1]) ha1++;
      if (pin_b[0]) hb0++;
      if (pin_b[1]) hb1++;
      if (busy[0])  bz0++;
      if (busy[1])  bz1++;
      if (sat_a[0]) sat_hi++;
      if (sat_a[1]) sat_hi++;
      if (sat_b != 2'b00) sat_lo++;
      if ((pin_a & pin_b) != 2'b00) overlap = 1'b1;
      if (period_tick) ticks++;
      if (glitch && k == 40) begin
        duty[7:0] = 8'd0;
        dir[0]    = ~dir[0];
      end
      if (glitch && k == 60) begin
        duty[7:0] = 8'd30;
        dir[0]    = ~dir[0];
      end
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    dir   = 2'b11;
    duty  = {8'd50, 8'd50};
    repeat (3) @(negedge khz100);
    cmp_count++;
    if ({pin_a, pin_b, busy, period_tick} !== 7'b0) begin
      $display("FAIL reset_outputs: got a=%b b=%b busy=%b tick=%b, want all 0", pin_a, pin_b, busy, period_tick);
      fail_count++;
    end
    cmp_count++;
    if ({sat_a, sat_b, sat_busy} !== 6'b0) begin
      $display("FAIL reset_sat_outputs: got a=%b b=%b busy=%b, want all 0", sat_a, sat_b, sat_busy);
      fail_count++;
    end
    rst_n = 1'b1;
    dir   = 2'b01;
    duty  = {8'd20, 8'd35};
    n = 0;
    overlap = 1'b0;
    while (!period_tick && n < 300) begin
      @(negedge khz100);
      n++;
      if ((pin_a | pin_b) != 2'b00) overlap = 1'b1;
    end
    cmp_count++;
    if (n !== 99) begin
      $display("FAIL reset_cnt_restart: first tick after %0d clocks, want 99", n);
      fail_count++;
    end
    cmp_count++;
    if (overlap !== 1'b0) begin
      $display("FAIL reset_first_period: pins driven in first period, want all low");
      fail_count++;
    end
  endtask

  task automatic test_ramp_up;
    int exp_a0[5]  = '{10, 20, 30, 35, 35};
    int exp_b1[5]  = '{0, 0, 0, 10, 20};
    int exp_bz1[5] = '{100, 100, 0, 0, 0};
    sync_period();
    for (int p = 0; p < 5; p++) begin
      measure(1'b0);
      cmp_count++;
      if (ha0 !== exp_a0[p] || hb0 !== 0) begin
        $display("FAIL ramp_ch0 p%0d: got a=%0d b=%0d, want a=%0d b=0", p, ha0, hb0, exp_a0[p]);
        fail_count++;
      end
      cmp_count++;
      if (hb1 !== exp_b1[p] || ha1 !== 0 || bz1 !== exp_bz1[p]) begin
        $display("FAIL zero_reversal_ch1 p%0d: got a=%0d b=%0d busy=%0d, want a=0 b=%0d busy=%0d",
                 p, ha1, hb1, bz1, exp_b1[p], exp_bz1[p]);
        fail_count++;
      end
      cmp_count++;
      if (ticks !== 1) begin
        $display("FAIL period_tick p%0d: got %0d ticks, want 1", p, ticks);
        fail_count++;
      end
      cmp_count++;
      if (sat_hi !== 200 || sat_lo !== 0) begin
        $display("FAIL saturation p%0d: got high=%0d pin_b=%0d, want high=200 pin_b=0", p, sat_hi, sat_lo);
        fail_count++;
      end
    end
  endtask

  task automatic test_reversal;
    int exp_a0[10]  = '{35, 30, 20, 10, 0, 0, 0, 0, 0, 0};
    int exp_b0[10]  = '{0, 0, 0, 0, 0, 0, 0, 10, 20, 30};
    int exp_bz0[10] = '{0, 0, 100, 100, 100, 100, 0, 0, 0, 0};
    duty[7:0] = 8'd30;
    for (int p = 0; p < 10; p++) begin
      if (p == 1) dir[0] = 1'b0;
      measure(1'b0);
      cmp_count++;
      if (ha0 !== exp_a0[p] || hb0 !== exp_b0[p] || bz0 !== exp_bz0[p]) begin
        $display("FAIL reversal p%0d: got a=%0d b=%0d busy=%0d, want a=%0d b=%0d busy=%0d",
                 p, ha0, hb0, bz0, exp_a0[p], exp_b0[p], exp_bz0[p]);
        fail_count++;
      end
      cmp_count++;
      if (overlap !== 1'b0 || hb1 !== 20) begin
        $display("FAIL reversal_overlap_ch1 p%0d: got overlap=%b ch1_b=%0d, want overlap=0 ch1_b=20", p, overlap, hb1);
        fail_count++;
      end
    end
  endtask

  task automatic test_abort;
    int exp_b0[4]  = '{30, 20, 20, 30};
    int exp_bz0[4] = '{0, 100, 0, 0};
    for (int p = 0; p < 4; p++) begin
      if (p == 0) dir[0] = 1'b1;
      if (p == 1) dir[0] = 1'b0;
      measure(1'b0);
      cmp_count++;
      if (hb0 !== exp_b0[p] || ha0 !== 0 || bz0 !== exp_bz0[p]) begin
        $display("FAIL abort p%0d: got a=%0d b=%0d busy=%0d, want a=0 b=%0d busy=%0d",
                 p, ha0, hb0, bz0, exp_b0[p], exp_bz0[p]);
        fail_count++;
      end
    end
  endtask

  task automatic test_midperiod_ignore;
    for (int p = 0; p < 2; p++) begin
      measure(p == 0);
      cmp_count++;
      if (hb0 !== 30 || ha0 !== 0 || bz0 !== 0) begin
        $display("FAIL midperiod_ignore p%0d: got a=%0d b=%0d busy=%0d, want a=0 b=30 busy=0", p, ha0, hb0, bz0);
        fail_count++;
      end
    end
  endtask

`ifdef MOTOR_BRAKE_EN
  task automatic test_brake;
    repeat (30) @(negedge khz100);
    brake[0] = 1'b1;
    @(negedge khz100);
    cmp_count++;
    if (pin_a[0] !== 1'b1 || pin_b[0] !== 1'b1 || busy[0] !== 1'b0) begin
      $display("FAIL brake_pins: got a=%b b=%b busy=%b, want a=1 b=1 busy=0", pin_a[0], pin_b[0], busy[0]);
      fail_count++;
    end
    repeat (5) @(negedge khz100);
    brake[0] = 1'b0;
    sync_period();
    for (int p = 0; p < 2; p++) begin
      measure(1'b0);
      cmp_count++;
      if (hb0 !== 10 * (p + 1) || ha0 !== 0) begin
        $display("FAIL brake_release p%0d: got a=%0d b=%0d, want a=0 b=%0d", p, ha0, hb0, 10 * (p + 1));
        fail_count++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_abort();
    test_midperiod_ignore();
`ifdef MOTOR_BRAKE_EN
    test_brake();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule
